coin_input_conditioner: RTL and testbench

Front end of the cola vending path. Takes the two raw mechanical coin keys (0.5 and 1.0 units) and conditions each one: synchronise, debounce, press-detect. It emits clean single-cycle pulses, at most one per cycle, that drive the vending FSM's half-coin and one-coin inputs directly.

---
 rtl/coin_pkg.sv | 14 +
 rtl/coin_key_debounce.sv | 84 ++++++++
 rtl/coin_input_conditioner.sv | 79 +++++++
 tb/tb_coin_input_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared definitions for the coin input path: channel FSM encoding and channel indices.
package coin_pkg;

    typedef enum logic [3:0] {
        ST_RELEASED  = 4'b0001,
        ST_PRESS_FLT = 4'b0010,
        ST_HELD      = 4'b0100,
        ST_REL_FLT   = 4'b1000
    } key_state_e;

    localparam int CH_HALF = 0;
    localparam int CH_ONE  = 1;

endpackage

// File: rtl/coin_key_debounce.sv
// One coin key channel: 2-FF synchroniser, press/release debounce FSM, single-cycle hit.
module coin_key_debounce
    import coin_pkg::*;
#(
    parameter int CNT_MAX = 999_999
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic hit_o
);

    localparam int            CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic          s1_q, s2_q;
    logic          vld_q, armed_q;
    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A press already held across reset release must not count: the channel
    // only arms once a genuinely sampled released level has been seen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            vld_q   <= 1'b0;
            armed_q <= 1'b0;
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
        end else begin
            s1_q    <= key_n_i;
            s2_q    <= s1_q;
            vld_q   <= 1'b1;
            armed_q <= armed_q | (vld_q & s1_q);
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_o   = 1'b0;
        unique case (state_q)
            ST_RELEASED: begin
                cnt_d = '0;
                if (!s2_q && armed_q) state_d = ST_PRESS_FLT;
            end
            ST_PRESS_FLT: begin
                if (s2_q) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    hit_o   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HELD: begin
                cnt_d = '0;
                if (s2_q) state_d = ST_REL_FLT;
            end
            ST_REL_FLT: begin
                if (!s2_q) begin
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASED;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_RELEASED;
            end
        endcase
    end

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin key front end: two debounced channels, one/half arbitration with a one-deep
// pending half, registered pulses. Optional post-pulse lockout under COIN_LOCKOUT_EN.
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int CNT_MAX  = 999_999
`ifdef COIN_LOCKOUT_EN
    ,
    parameter int LOCK_CYC = 49_999
`endif
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_half_n,
    input  logic key_one_n,
    output logic po_money_half,
    output logic po_money_one
);

    logic [1:0] hit, hit_ok;
    logic       half_q, half_d, one_q, one_d, pend_q, pend_d;

    coin_key_debounce #(.CNT_MAX(CNT_MAX)) u_half (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .key_n_i (key_half_n),
        .hit_o   (hit[CH_HALF])
    );

    coin_key_debounce #(.CNT_MAX(CNT_MAX)) u_one (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .key_n_i (key_one_n),
        .hit_o   (hit[CH_ONE])
    );

`ifdef COIN_LOCKOUT_EN
    localparam int LW = $clog2(LOCK_CYC + 1);
    logic [LW-1:0] lock_q, lock_d;

    // Hits during lockout are dropped; the pending half bypasses this gate.
    assign hit_ok = (lock_q != '0) ? 2'b00 : hit;

    always_comb begin
        lock_d = lock_q;
        if (half_d || one_d)  lock_d = LW'(LOCK_CYC);
        else if (lock_q != '0) lock_d = lock_q - LW'(1);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) lock_q <= '0;
        else         lock_q <= lock_d;
    end
`else
    assign hit_ok = hit;
`endif

    always_comb begin
        one_d  = hit_ok[CH_ONE];
        half_d = pend_q | (hit_ok[CH_HALF] & ~hit_ok[CH_ONE]);
        pend_d = hit_ok[CH_HALF] & hit_ok[CH_ONE];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            half_q <= 1'b0;
            one_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            half_q <= half_d;
            one_q  <= one_d;
            pend_q <= pend_d;
        end
    end

    assign po_money_half = half_q;
    assign po_money_one  = one_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed scoreboard bench for coin_input_conditioner (CNT_MAX=4, LOCK_CYC=8).
module tb_coin_input_conditioner;

    typedef struct {
        bit ch;    // 0 = half, 1 = one
        int cyc;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_half_n = 1'b1;
    logic key_one_n  = 1'b1;
    logic po_money_half, po_money_one;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    coin_input_conditioner #(
        .CNT_MAX (4)
`ifdef COIN_LOCKOUT_EN
        ,
        .LOCK_CYC(8)
`endif
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_half_n   (key_half_n),
        .key_one_n    (key_one_n),
        .po_money_half(po_money_half),
        .po_money_one (po_money_one)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // A key driven at a negedge (cyc=c) is first sampled at edge c+1; the pulse is
    // visible after edge c+1+CNT_MAX+2, i.e. at the negedge where cyc == c+7.
    task automatic expect_pulse(input bit ch, input int at);
        exp_t e;
        e.ch  = ch;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic check_drained(input string tag);
        n_tests++;
        assert (sb.size() === 0) else begin
            n_fail++;
            $error("FAIL %s: pending expected pulses %0d, required 0", tag, sb.size());
        end
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (po_money_half || po_money_one) begin
            n_tests++;
            assert (!(po_money_half && po_money_one)) else begin
                n_fail++;
                $error("FAIL overlap: half=%0b one=%0b at cyc %0d, required not both", po_money_half, po_money_one, cyc);
            end
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_pulse: half=%0b one=%0b at cyc %0d, required no pulse", po_money_half, po_money_one, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_tests++;
                assert (po_money_one === e.ch) else begin
                    n_fail++;
                    $error("FAIL pulse_channel: one=%0b at cyc %0d, required one=%0b", po_money_one, cyc, e.ch);
                end
                n_tests++;
                assert (cyc === e.cyc) else begin
                    n_fail++;
                    $error("FAIL pulse_cycle: got cyc %0d, required cyc %0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        // reset state
        step(3);
        n_tests++;
        assert (po_money_half === 1'b0) else begin
            n_fail++; $error("FAIL reset_half: got %0b, required 0", po_money_half);
        end
        n_tests++;
        assert (po_money_one === 1'b0) else begin
            n_fail++; $error("FAIL reset_one: got %0b, required 0", po_money_one);
        end
        sys_rst = 1'b0;
        step(5);

        // clean half press
        key_half_n = 1'b0;
        expect_pulse(1'b0, cyc + 7);
        step(20);
        key_half_n = 1'b1;
        step(15);
        check_drained("clean_press");

        // bouncing one press rejected, then a real one accepted
        key_one_n = 1'b0; step(3);
        key_one_n = 1'b1; step(1);
        key_one_n = 1'b0; step(3);
        key_one_n = 1'b1; step(10);
        check_drained("bounce_reject");
        key_one_n = 1'b0;
        expect_pulse(1'b1, cyc + 7);
        step(10);
        key_one_n = 1'b1;
        step(15);
        check_drained("bounce_then_press");

        // simultaneous: one first, half the next cycle
        key_half_n = 1'b0;
        key_one_n  = 1'b0;
        expect_pulse(1'b1, cyc + 7);
        expect_pulse(1'b0, cyc + 8);
        step(20);
        key_half_n = 1'b1;
        key_one_n  = 1'b1;
        step(15);
        check_drained("simultaneous");

        // long hold with a bouncy release
        key_half_n = 1'b0;
        expect_pulse(1'b0, cyc + 7);
        step(100);
        key_half_n = 1'b1; step(2);
        key_half_n = 1'b0; step(1);
        key_half_n = 1'b1; step(15);
        check_drained("long_hold");

        // reset at cnt=2 with the key kept low
        key_half_n = 1'b0;
        step(5);
        sys_rst = 1'b1;
        step(1);
        n_tests++;
        assert (po_money_half === 1'b0 && po_money_one === 1'b0) else begin
            n_fail++; $error("FAIL mid_reset_outputs: half=%0b one=%0b, required 0/0", po_money_half, po_money_one);
        end
        step(1);
        n_tests++;
        assert (po_money_half === 1'b0 && po_money_one === 1'b0) else begin
            n_fail++; $error("FAIL mid_reset_outputs2: half=%0b one=%0b, required 0/0", po_money_half, po_money_one);
        end
        sys_rst = 1'b0;
        step(20);
        check_drained("straddle_no_pulse");
        key_half_n = 1'b1;
        step(10);
        key_half_n = 1'b0;
        expect_pulse(1'b0, cyc + 7);
        step(10);
        key_half_n = 1'b1;
        step(15);
        check_drained("press_after_reset");

`ifdef COIN_LOCKOUT_EN
        // one hit 4 cycles after the half pulse is discarded
        key_half_n = 1'b0;
        expect_pulse(1'b0, cyc + 7);
        step(4);
        key_one_n = 1'b0;
        step(20);
        key_half_n = 1'b1;
        key_one_n  = 1'b1;
        step(15);
        check_drained("lockout_suppress");
        // one hit 12 cycles after the half pulse is accepted
        key_half_n = 1'b0;
        expect_pulse(1'b0, cyc + 7);
        step(12);
        key_one_n = 1'b0;
        expect_pulse(1'b1, cyc + 7);
        step(20);
        key_half_n = 1'b1;
        key_one_n  = 1'b1;
        step(15);
        check_drained("lockout_expired");
`endif

        check_drained("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
